// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package ifu_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam int          ILEN_DEF     = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam int          INST_BYTES   = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FAULT = 2'd1,
        HALT  = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] inst;
        logic                fault;
    } fetch_slot_t;

    // Instructions are word aligned; any low-bit set is a misaligned target.
    function automatic logic is_misaligned(input logic [XLEN_DEF-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ROM, redirect and decode-side handshake bundle of the fetch stage.
// master = fetch stage, slave = its environment (ROM, execute, decode).
interface ifu_fetch_if
    import ifu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ILEN = ILEN_DEF
);
    logic [XLEN-1:0] rom_pc;
    logic [ILEN-1:0] rom_inst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_inst;
    logic            out_fault;

    modport master (
        output rom_pc,
        input  rom_inst,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        output out_fault
    );

    modport slave (
        input  rom_pc,
        output rom_inst,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        input  out_fault
    );
endinterface

// File: rtl/ifu_pc_gen.sv
// Architectural PC register: takes aligned redirects, advances by one
// instruction on fetch, otherwise holds. Misaligned redirects leave it alone.
module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    assign misalign_o = is_misaligned(redirect_pc_i);
    assign pc_o       = pc_q;

    // Next PC: redirect wins over sequential advance; +4 wraps silently.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            if (!misalign_o) begin
                pc_d = redirect_pc_i;
            end
        end else if (advance_i) begin
            pc_d = pc_q + XLEN'(INST_BYTES);
        end
    end

    // PC register with synchronous reset to the ROM base.
    always_ff @(posedge clk) begin
        if (srst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: drives the ROM address from the PC, captures
// {pc, inst} into a single registered output slot, handles redirects and
// turns misaligned targets into a fault record followed by a halt.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter int               ILEN     = ILEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ifu_fetch_if.master   bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]   perf_fetch_cnt,
    output logic [63:0]   perf_flush_cnt
`endif
);

    ifu_state_e  state_q, state_d;
    fetch_slot_t slot_q,  slot_d;
    logic        valid_q, valid_d;

    logic [XLEN-1:0] pc;
    logic            redirect_misaligned;
    logic            fetch_en;
    logic            slot_free;
    logic            transfer;

    assign slot_free = !valid_q || bus.out_ready;
    assign transfer  = valid_q && bus.out_ready;

    ifu_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk              (clk),
        .srst             (rst),
        .redirect_valid_i (bus.redirect_valid),
        .redirect_pc_i    (bus.redirect_pc),
        .advance_i        (fetch_en),
        .pc_o             (pc),
        .misalign_o       (redirect_misaligned)
    );

    assign bus.rom_pc    = pc;
    assign bus.out_valid = valid_q;
    assign bus.out_pc    = slot_q.pc;
    assign bus.out_inst  = slot_q.inst;
    assign bus.out_fault = slot_q.fault;

    // Next state and slot contents: redirect overrides everything; otherwise
    // RUN fetches into a free slot, FAULT waits for acceptance, HALT idles.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        valid_d  = valid_q;
        fetch_en = 1'b0;
        if (bus.redirect_valid) begin
            if (redirect_misaligned) begin
                valid_d     = 1'b1;
                slot_d.pc   = bus.redirect_pc;
                slot_d.inst = '0;
                slot_d.fault = 1'b1;
                state_d     = FAULT;
            end else begin
                valid_d = 1'b0;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (slot_free) begin
                        fetch_en     = 1'b1;
                        valid_d      = 1'b1;
                        slot_d.pc    = pc;
                        slot_d.inst  = bus.rom_inst;
                        slot_d.fault = 1'b0;
                    end
                end
                FAULT: begin
                    if (transfer) begin
                        valid_d = 1'b0;
                        state_d = HALT;
                    end
                end
                HALT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = HALT;
                end
            endcase
        end
    end

    // State and output slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            slot_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [63:0] fetch_cnt_q;
    logic [63:0] flush_cnt_q;

    // Count accepted real instructions and slots discarded by a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (transfer && !slot_q.fault) begin
                fetch_cnt_q <= fetch_cnt_q + 64'd1;
            end
            if (bus.redirect_valid && valid_q && !bus.out_ready) begin
                flush_cnt_q <= flush_cnt_q + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch stream.
module tb_ifu_fetch;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ifu_fetch_if bus ();

`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_flush_cnt;
`endif

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // ROM content: an arbitrary but distinct word per address.
    function automatic logic [31:0] rom_word(input logic [63:0] addr);
        logic [31:0] lo;
        lo = addr[31:0];
        return (lo * 32'h0019_660D + 32'h3C6E_F35F) ^ addr[63:32];
    endfunction

    assign bus.rom_inst = rom_word(bus.rom_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        tick();
        total++;
        if ({bus.out_valid, bus.out_pc, bus.out_inst, bus.out_fault} !== {1'b0, 64'h0, 32'h0, 1'b0})
            $display("FAIL reset_slot: got v=%0d pc=%h inst=%h f=%0d want all zero",
                     bus.out_valid, bus.out_pc, bus.out_inst, bus.out_fault);
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 64'h0 || bus.out_inst !== 32'h0 || bus.out_fault !== 1'b0) bad++;
        total++;
        if (bus.rom_pc !== BASE) begin
            bad++;
            $display("FAIL reset_rom_pc: got %h want %h", bus.rom_pc, BASE);
        end
`ifdef IFU_PERF_CNT_EN
        total++;
        if (perf_fetch_cnt !== 64'd0 || perf_flush_cnt !== 64'd0) begin
            bad++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", perf_fetch_cnt, perf_flush_cnt);
        end
`endif
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== BASE || bus.out_inst !== rom_word(BASE)) begin
            bad++;
            $display("FAIL first_fetch: got v=%0d pc=%h inst=%h want v=1 pc=%h inst=%h",
                     bus.out_valid, bus.out_pc, bus.out_inst, BASE, rom_word(BASE));
        end
        $display("reset: first slot pc=%h inst=%h", bus.out_pc, bus.out_inst);
    endtask

    task automatic test_stream();
        logic [63:0] exp_pc;
        for (int i = 1; i < 4; i++) begin
            tick();
            exp_pc = BASE + 64'(4 * i);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc ||
                bus.out_inst !== rom_word(exp_pc) || bus.out_fault !== 1'b0) begin
                bad++;
                $display("FAIL stream_%0d: got v=%0d pc=%h inst=%h want pc=%h inst=%h",
                         i, bus.out_valid, bus.out_pc, bus.out_inst, exp_pc, rom_word(exp_pc));
            end
            $display("stream: slot pc=%h inst=%h", bus.out_pc, bus.out_inst);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== BASE + 64'h4 ||
                bus.out_inst !== rom_word(BASE + 64'h4) || bus.rom_pc !== BASE + 64'h8) begin
                bad++;
                $display("FAIL backpressure_hold_%0d: got v=%0d pc=%h inst=%h rom_pc=%h want pc=%h rom_pc=%h",
                         k, bus.out_valid, bus.out_pc, bus.out_inst, bus.rom_pc, BASE + 64'h4, BASE + 64'h8);
            end
        end
        bus.out_ready = 1'b1;
        for (int k = 2; k < 5; k++) begin
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== BASE + 64'(4 * k) ||
                bus.out_inst !== rom_word(BASE + 64'(4 * k))) begin
                bad++;
                $display("FAIL backpressure_resume_%0d: got v=%0d pc=%h want pc=%h",
                         k, bus.out_valid, bus.out_pc, BASE + 64'(4 * k));
            end
        end
        $display("backpressure: resumed at slot pc=%h", bus.out_pc);
    endtask

    task automatic test_redirect();
`ifdef IFU_PERF_CNT_EN
        logic [63:0] fl0;
        fl0 = perf_flush_cnt;
`endif
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = BASE + 64'h100;
        tick();
        bus.redirect_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.rom_pc !== BASE + 64'h100) begin
            bad++;
            $display("FAIL redirect_flush: got v=%0d rom_pc=%h want v=0 rom_pc=%h",
                     bus.out_valid, bus.rom_pc, BASE + 64'h100);
        end
`ifdef IFU_PERF_CNT_EN
        total++;
        if (perf_flush_cnt !== fl0 + 64'd1) begin
            bad++;
            $display("FAIL redirect_flush_cnt: got %0d want %0d", perf_flush_cnt, fl0 + 64'd1);
        end
`endif
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== BASE + 64'h100 || bus.out_inst !== rom_word(BASE + 64'h100)) begin
            bad++;
            $display("FAIL redirect_target: got v=%0d pc=%h want pc=%h", bus.out_valid, bus.out_pc, BASE + 64'h100);
        end
        $display("redirect: target slot pc=%h", bus.out_pc);
        bus.out_ready = 1'b1;
    endtask

    task automatic test_misaligned();
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = BASE + 64'h102;
        tick();
        bus.redirect_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.out_pc, bus.out_inst, bus.out_fault} !== {1'b1, BASE + 64'h102, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL misaligned_fault: got v=%0d pc=%h inst=%h f=%0d want v=1 pc=%h inst=0 f=1",
                     bus.out_valid, bus.out_pc, bus.out_inst, bus.out_fault, BASE + 64'h102);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL halt_idle_%0d: got v=%0d want 0", k, bus.out_valid);
            end
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = BASE + 64'h200;
        tick();
        bus.redirect_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.rom_pc !== BASE + 64'h200) begin
            bad++;
            $display("FAIL halt_exit: got v=%0d rom_pc=%h want v=0 rom_pc=%h", bus.out_valid, bus.rom_pc, BASE + 64'h200);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== BASE + 64'h200 || bus.out_fault !== 1'b0) begin
            bad++;
            $display("FAIL halt_resume: got v=%0d pc=%h f=%0d want v=1 pc=%h f=0",
                     bus.out_valid, bus.out_pc, bus.out_fault, BASE + 64'h200);
        end
        $display("misaligned: fault taken, resumed at pc=%h", bus.out_pc);
    endtask

    task automatic test_redirect_transfer();
`ifdef IFU_PERF_CNT_EN
        logic [63:0] f0, fl0;
        f0  = perf_fetch_cnt;
        fl0 = perf_flush_cnt;
`endif
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = BASE + 64'h40;
        tick();
        bus.redirect_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL xfer_redirect_valid: got %0d want 0", bus.out_valid);
        end
`ifdef IFU_PERF_CNT_EN
        total++;
        if (perf_fetch_cnt !== f0 + 64'd1 || perf_flush_cnt !== fl0) begin
            bad++;
            $display("FAIL xfer_redirect_cnt: got fetch=%0d flush=%0d want fetch=%0d flush=%0d",
                     perf_fetch_cnt, perf_flush_cnt, f0 + 64'd1, fl0);
        end
`endif
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== BASE + 64'h40) begin
            bad++;
            $display("FAIL xfer_redirect_target: got v=%0d pc=%h want pc=%h", bus.out_valid, bus.out_pc, BASE + 64'h40);
        end
        $display("redirect+transfer: target slot pc=%h", bus.out_pc);
    endtask

    task automatic test_wrap_reset();
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC ||
            bus.out_inst !== rom_word(64'hFFFF_FFFF_FFFF_FFFC)) begin
            bad++;
            $display("FAIL wrap_top: got v=%0d pc=%h want pc=fffffffffffffffc", bus.out_valid, bus.out_pc);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_inst !== rom_word(64'h0)) begin
            bad++;
            $display("FAIL wrap_zero: got v=%0d pc=%h want pc=0", bus.out_valid, bus.out_pc);
        end
        rst = 1'b1;
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.rom_pc !== BASE) begin
            bad++;
            $display("FAIL midrun_reset: got v=%0d rom_pc=%h want v=0 rom_pc=%h", bus.out_valid, bus.rom_pc, BASE);
        end
`ifdef IFU_PERF_CNT_EN
        total++;
        if (perf_fetch_cnt !== 64'd0 || perf_flush_cnt !== 64'd0) begin
            bad++;
            $display("FAIL midrun_reset_cnt: got %0d/%0d want 0/0", perf_fetch_cnt, perf_flush_cnt);
        end
`endif
        rst = 1'b0;
        $display("wrap: pcs fffffffffffffffc then 0, reset back to %h", bus.rom_pc);
    endtask

    // Randomized run against a stream model: the next sequential PC, the
    // expected slot contents, and whether a fault is pending or fetch halted.
    task automatic test_random();
        logic [63:0] next_pc;
        logic        s_valid, s_fault;
        logic [63:0] s_pc;
        logic [31:0] s_inst;
        logic        fault_pending, halted;
        logic [63:0] n_fetch, n_flush;
        logic        do_rst, redir, ready, xfer;
        logic [63:0] tgt;
        int          r;

        do_reset();
        next_pc = BASE;
        s_valid = 1'b0; s_fault = 1'b0; s_pc = '0; s_inst = '0;
        fault_pending = 1'b0; halted = 1'b0;
        n_fetch = '0; n_flush = '0;

        for (int c = 0; c < 500; c++) begin
            r      = int'($urandom_range(0, 99));
            do_rst = (r == 0);
            redir  = !do_rst && (r < 9);
            ready  = ($urandom_range(0, 3) != 0);
            tgt    = BASE + 64'($urandom_range(0, 1023)) * 64'd4;
            if ($urandom_range(0, 3) == 0) tgt = tgt + 64'($urandom_range(1, 3));

            rst = do_rst;
            bus.out_ready = ready;
            bus.redirect_valid = redir;
            bus.redirect_pc = tgt;
            tick();

            xfer = s_valid && ready && !do_rst;
            if (xfer) $display("rand xfer: pc=%h inst=%h fault=%0d", s_pc, s_inst, s_fault);
            if (do_rst) begin
                next_pc = BASE;
                s_valid = 1'b0;
                fault_pending = 1'b0; halted = 1'b0;
                n_fetch = '0; n_flush = '0;
            end else begin
                if (xfer && !s_fault) n_fetch++;
                if (redir && s_valid && !ready) n_flush++;
                if (redir) begin
                    if (tgt[1:0] == 2'b00) begin
                        s_valid = 1'b0;
                        next_pc = tgt;
                        fault_pending = 1'b0; halted = 1'b0;
                    end else begin
                        s_valid = 1'b1; s_pc = tgt; s_inst = '0; s_fault = 1'b1;
                        fault_pending = 1'b1; halted = 1'b0;
                    end
                end else if (fault_pending) begin
                    if (xfer) begin
                        s_valid = 1'b0;
                        fault_pending = 1'b0; halted = 1'b1;
                    end
                end else if (halted) begin
                    s_valid = 1'b0;
                end else if (!s_valid || ready) begin
                    s_valid = 1'b1; s_pc = next_pc; s_inst = rom_word(next_pc); s_fault = 1'b0;
                    next_pc = next_pc + 64'd4;
                end
            end

            total++;
            if (bus.out_valid !== s_valid) begin
                bad++;
                $display("FAIL rand_valid@%0d: got %0d want %0d", c, bus.out_valid, s_valid);
            end
            if (s_valid) begin
                total++;
                if ({bus.out_pc, bus.out_inst, bus.out_fault} !== {s_pc, s_inst, s_fault}) begin
                    bad++;
                    $display("FAIL rand_slot@%0d: got pc=%h inst=%h f=%0d want pc=%h inst=%h f=%0d",
                             c, bus.out_pc, bus.out_inst, bus.out_fault, s_pc, s_inst, s_fault);
                end
            end
            total++;
            if (bus.rom_pc !== next_pc) begin
                bad++;
                $display("FAIL rand_rom_pc@%0d: got %h want %h", c, bus.rom_pc, next_pc);
            end
`ifdef IFU_PERF_CNT_EN
            total++;
            if (perf_fetch_cnt !== n_fetch || perf_flush_cnt !== n_flush) begin
                bad++;
                $display("FAIL rand_cnt@%0d: got %0d/%0d want %0d/%0d",
                         c, perf_fetch_cnt, perf_flush_cnt, n_fetch, n_flush);
            end
`endif
        end
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_redirect_transfer();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
